// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types and constants for the RQ/GRANT bus arbiter.
package bus_arbiter_rr_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        OWNED      = 2'd1,
        TURNAROUND = 2'd2
    } arbState_t;

    localparam logic PRIO_RR    = 1'b0;
    localparam logic PRIO_FIXED = 1'b1;

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// RQ/GRANT handshake bundle between the cores' arbitration submodules and the arbiter.
interface bus_arbiter_rr_if #(
    parameter int N_MASTERS = 4
);
    localparam int ID_W = $clog2(N_MASTERS);

    logic [N_MASTERS-1:0] rq;
    logic                 prio_mode;
    logic [N_MASTERS-1:0] grant;
    logic [ID_W-1:0]      grant_id;
    logic                 bus_busy;
    logic                 timeout_pulse;
    logic [ID_W-1:0]      timeout_id;

    modport master (
        output rq, prio_mode,
        input  grant, grant_id, bus_busy, timeout_pulse, timeout_id
    );

    modport slave (
        input  rq, prio_mode,
        output grant, grant_id, bus_busy, timeout_pulse, timeout_id
    );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational winner selection: lowest set request at or after ptr (wrapping),
// or plain lowest index in fixed-priority mode.
module rr_priority_picker
    import bus_arbiter_rr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 mode,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IW = $clog2(N);
    localparam int FW = $clog2(2 * N);

    logic [IW-1:0]  basePtr;
    logic [N-1:0]   maskedReq;
    logic [2*N-1:0] dblReq;
    logic [FW-1:0]  hit;

    assign basePtr = (mode == PRIO_FIXED) ? '0 : ptr;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign maskedReq[gi] = req[gi] & (IW'(gi) >= basePtr);
        end
    endgenerate

    // Lower half holds only requests at/after the pointer; the upper half is the
    // unmasked copy, so a miss below naturally wraps around to index 0 and up.
    assign dblReq = {req, maskedReq};

    always_comb begin
        hit = '0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (dblReq[i]) begin
                hit = FW'(i);
            end
        end
    end

    assign valid = |req;
    assign idx   = (hit >= FW'(N)) ? IW'(hit - FW'(N)) : IW'(hit);

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master RQ/GRANT bus arbiter: round-robin or fixed priority, turnaround gap,
// and an optional tenure watchdog that revokes and locks out a stuck owner.
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int N_MASTERS  = 4,
    parameter int GAP_CYCLES = 1,
    parameter int MAX_TENURE = 0
) (
    input logic               clk,
    input logic               reset,
    bus_arbiter_rr_if.slave   bus
);
    localparam int ID_W = $clog2(N_MASTERS);
    localparam int TW   = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;
    localparam int GW   = $clog2(GAP_CYCLES + 1);

    arbState_t            stateReg, stateNext;
    logic [ID_W-1:0]      rrPtrReg, rrPtrNext;
    logic [TW-1:0]        tenureReg, tenureNext;
    logic [GW-1:0]        gapReg, gapNext;
    logic [N_MASTERS-1:0] lockoutReg, lockoutNext;
    logic [N_MASTERS-1:0] grantReg, grantNext;
    logic [ID_W-1:0]      grantIdReg, grantIdNext;
    logic                 timeoutPulseReg, timeoutPulseNext;
    logic [ID_W-1:0]      timeoutIdReg, timeoutIdNext;

    logic [N_MASTERS-1:0] eligible;
    logic                 pickValid;
    logic [ID_W-1:0]      pickIdx;
    logic [ID_W-1:0]      ownerPlusOne;
    logic                 ownerReq;
    logic                 tenureLimit;

    assign eligible = bus.rq & ~lockoutReg;

    rr_priority_picker #(.N(N_MASTERS)) picker (
        .req   (eligible),
        .ptr   (rrPtrReg),
        .mode  (bus.prio_mode),
        .valid (pickValid),
        .idx   (pickIdx)
    );

    assign ownerPlusOne = (grantIdReg == ID_W'(N_MASTERS - 1)) ? '0 : grantIdReg + 1'b1;
    assign ownerReq     = bus.rq[grantIdReg];
    assign tenureLimit  = (MAX_TENURE != 0) && (tenureReg == TW'(MAX_TENURE));

    always_comb begin
        stateNext        = stateReg;
        rrPtrNext        = rrPtrReg;
        tenureNext       = tenureReg;
        gapNext          = gapReg;
        grantNext        = grantReg;
        grantIdNext      = grantIdReg;
        timeoutPulseNext = 1'b0;
        timeoutIdNext    = timeoutIdReg;
        // A locked-out master is readmitted once it has dropped its request.
        lockoutNext      = lockoutReg & bus.rq;

        unique case (stateReg)
            IDLE: begin
                if (pickValid) begin
                    grantNext   = {{(N_MASTERS-1){1'b0}}, 1'b1} << pickIdx;
                    grantIdNext = pickIdx;
                    tenureNext  = TW'(1);
                    stateNext   = OWNED;
                end
            end
            OWNED: begin
                if (!ownerReq || tenureLimit) begin
                    grantNext = '0;
                    rrPtrNext = ownerPlusOne;
                    gapNext   = GW'(GAP_CYCLES);
                    stateNext = TURNAROUND;
                    // A voluntary drop on the limit cycle wins: no revoke is reported.
                    if (ownerReq) begin
                        timeoutPulseNext        = 1'b1;
                        timeoutIdNext           = grantIdReg;
                        lockoutNext[grantIdReg] = 1'b1;
                    end
                end else if (tenureReg != {TW{1'b1}}) begin
                    tenureNext = tenureReg + 1'b1;
                end
            end
            TURNAROUND: begin
                grantNext = '0;
                gapNext   = gapReg - 1'b1;
                if (gapReg <= GW'(1)) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                grantNext = '0;
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg        <= IDLE;
            rrPtrReg        <= '0;
            tenureReg       <= '0;
            gapReg          <= '0;
            lockoutReg      <= '0;
            grantReg        <= '0;
            grantIdReg      <= '0;
            timeoutPulseReg <= 1'b0;
            timeoutIdReg    <= '0;
        end else begin
            stateReg        <= stateNext;
            rrPtrReg        <= rrPtrNext;
            tenureReg       <= tenureNext;
            gapReg          <= gapNext;
            lockoutReg      <= lockoutNext;
            grantReg        <= grantNext;
            grantIdReg      <= grantIdNext;
            timeoutPulseReg <= timeoutPulseNext;
            timeoutIdReg    <= timeoutIdNext;
        end
    end

    assign bus.grant         = grantReg;
    assign bus.grant_id      = grantIdReg;
    assign bus.bus_busy      = |grantReg;
    assign bus.timeout_pulse = timeoutPulseReg;
    assign bus.timeout_id    = timeoutIdReg;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr (N=4, GAP=1, MAX_TENURE=8): vector table plus
// hand-written asynchronous reset sequences, checked through an expectation queue.
module tb_bus_arbiter_rr;
    import bus_arbiter_rr_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter_rr_if #(.N_MASTERS(4)) bus ();

    bus_arbiter_rr #(
        .N_MASTERS  (4),
        .GAP_CYCLES (1),
        .MAX_TENURE (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] rq;
        logic       mode;
        logic [3:0] expGrant;
        logic       expPulse;
        logic [1:0] expToId;
        bit         doRst;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] grant;
        logic       pulse;
        logic [1:0] toId;
    } exp_t;

    vec_t vecs[$];
    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;

    function automatic logic [1:0] idOf(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0] rq, input logic mode, input logic [3:0] g,
                                input logic p, input logic [1:0] toId, input bit rst);
        vec_t v;
        v.rq = rq;
        v.mode = mode;
        v.expGrant = g;
        v.expPulse = p;
        v.expToId = toId;
        v.doRst = rst;
        return v;
    endfunction

    function automatic void addVec(input logic [3:0] rq, input logic mode, input logic [3:0] g,
                                   input logic p, input logic [1:0] toId, input bit rst);
        vecs.push_back(mk(rq, mode, g, p, toId, rst));
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0h want=%0h t=%0t", name, idx, got, want, $time);
        end
    endtask

    task automatic checkIdle(input string tag);
        check({tag, "_grant"}, -1, 32'(bus.grant), 32'd0);
        check({tag, "_busy"}, -1, 32'(bus.bus_busy), 32'd0);
        check({tag, "_grant_id"}, -1, 32'(bus.grant_id), 32'd0);
        check({tag, "_pulse"}, -1, 32'(bus.timeout_pulse), 32'd0);
        check({tag, "_timeout_id"}, -1, 32'(bus.timeout_id), 32'd0);
    endtask

    // Called just after a rising edge; asserts reset between edges.
    task automatic doReset();
        reset = 1'b0;
        bus.rq = 4'b0000;
        bus.prio_mode = PRIO_RR;
        #1;
        checkIdle("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic step(input vec_t v, input int idx);
        exp_t e;
        bus.rq = v.rq;
        bus.prio_mode = v.mode;
        e.idx = idx;
        e.grant = v.expGrant;
        e.pulse = v.expPulse;
        e.toId = v.expToId;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        check("grant", e.idx, 32'(bus.grant), 32'(e.grant));
        check("bus_busy", e.idx, 32'(bus.bus_busy), 32'(|e.grant));
        if (e.grant != 4'b0000)
            check("grant_id", e.idx, 32'(bus.grant_id), 32'(idOf(e.grant)));
        check("timeout_pulse", e.idx, 32'(bus.timeout_pulse), 32'(e.pulse));
        check("timeout_id", e.idx, 32'(bus.timeout_id), 32'(e.toId));
        $display("vec %0d rq=%b mode=%0d grant=%b id=%0d pulse=%0d toid=%0d", e.idx, v.rq, v.mode,
                 bus.grant, bus.grant_id, bus.timeout_pulse, bus.timeout_id);
    endtask

    initial begin
        logic [3:0] oh;
        bus.rq = 4'b0000;
        bus.prio_mode = PRIO_RR;

        // Single requester, release, and gap before regrant.
        addVec(4'b0010, 0, 4'b0010, 0, 0, 1);
        for (int k = 0; k < 4; k++) addVec(4'b0010, 0, 4'b0010, 0, 0, 0);
        addVec(4'b0000, 0, 4'b0000, 0, 0, 0);
        addVec(4'b0010, 0, 4'b0000, 0, 0, 0);
        addVec(4'b0010, 0, 4'b0010, 0, 0, 0);
        addVec(4'b0000, 0, 4'b0000, 0, 0, 0);
        addVec(4'b0000, 0, 4'b0000, 0, 0, 0);

        // Round-robin fairness with all masters requesting.
        for (int m = 0; m < 4; m++) begin
            oh = 4'b0001 << m;
            for (int k = 0; k < 3; k++) addVec(4'b1111, 0, oh, 0, 0, (m == 0) && (k == 0));
            addVec(4'b1111 & ~oh, 0, 4'b0000, 0, 0, 0);
            addVec(4'b1111, 0, 4'b0000, 0, 0, 0);
        end
        addVec(4'b1111, 0, 4'b0001, 0, 0, 0);
        addVec(4'b0000, 0, 4'b0000, 0, 0, 0);
        addVec(4'b0000, 0, 4'b0000, 0, 0, 0);

        // Fixed priority: owner keeps the bus, then lowest index beats round-robin order.
        addVec(4'b1100, 1, 4'b0100, 0, 0, 1);
        addVec(4'b1110, 1, 4'b0100, 0, 0, 0);
        addVec(4'b1100, 1, 4'b0100, 0, 0, 0);
        addVec(4'b1010, 1, 4'b0000, 0, 0, 0);
        addVec(4'b1010, 1, 4'b0000, 0, 0, 0);
        addVec(4'b1010, 1, 4'b0010, 0, 0, 0);
        addVec(4'b1010, 1, 4'b0010, 0, 0, 0);
        addVec(4'b1000, 1, 4'b0000, 0, 0, 0);
        addVec(4'b1000, 1, 4'b0000, 0, 0, 0);
        addVec(4'b1000, 1, 4'b1000, 0, 0, 0);
        addVec(4'b0000, 1, 4'b0000, 0, 0, 0);
        addVec(4'b0000, 1, 4'b0000, 0, 0, 0);

        // Watchdog revoke after 8 granted cycles, lockout until rq[2] drops.
        addVec(4'b0100, 0, 4'b0100, 0, 0, 1);
        for (int k = 0; k < 7; k++) addVec(4'b0100, 0, 4'b0100, 0, 0, 0);
        addVec(4'b0100, 0, 4'b0000, 1, 2, 0);
        addVec(4'b0101, 0, 4'b0000, 0, 2, 0);
        addVec(4'b0101, 0, 4'b0001, 0, 2, 0);
        addVec(4'b0101, 0, 4'b0001, 0, 2, 0);
        addVec(4'b0100, 0, 4'b0000, 0, 2, 0);
        addVec(4'b0100, 0, 4'b0000, 0, 2, 0);
        addVec(4'b0100, 0, 4'b0000, 0, 2, 0);
        addVec(4'b0000, 0, 4'b0000, 0, 2, 0);
        addVec(4'b0100, 0, 4'b0100, 0, 2, 0);
        addVec(4'b0000, 0, 4'b0000, 0, 2, 0);

        // Drop coincides with the tenure limit: ordinary release, no lockout.
        addVec(4'b0010, 0, 4'b0010, 0, 0, 1);
        for (int k = 0; k < 7; k++) addVec(4'b0010, 0, 4'b0010, 0, 0, 0);
        addVec(4'b0000, 0, 4'b0000, 0, 0, 0);
        addVec(4'b0000, 0, 4'b0000, 0, 0, 0);
        addVec(4'b0010, 0, 4'b0010, 0, 0, 0);
        addVec(4'b0000, 0, 4'b0000, 0, 0, 0);

        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].doRst) doReset();
            step(vecs[i], i);
        end

        // Asynchronous reset while master 3 owns the bus.
        doReset();
        step(mk(4'b0010, 0, 4'b0010, 0, 0, 0), 1000);
        step(mk(4'b0000, 0, 4'b0000, 0, 0, 0), 1001);
        step(mk(4'b0000, 0, 4'b0000, 0, 0, 0), 1002);
        step(mk(4'b1000, 0, 4'b1000, 0, 0, 0), 1003);
        step(mk(4'b1000, 0, 4'b1000, 0, 0, 0), 1004);
        #2;
        reset = 1'b0;
        #1;
        checkIdle("async_mid_tenure");
        #1;
        reset = 1'b1;
        step(mk(4'b1000, 0, 4'b1000, 0, 0, 0), 1005);
        step(mk(4'b0000, 0, 4'b0000, 0, 0, 0), 1006);
        step(mk(4'b0000, 0, 4'b0000, 0, 0, 0), 1007);

        // Pointer left at 2, then reset: the next pick must start from 0 again.
        step(mk(4'b0010, 0, 4'b0010, 0, 0, 0), 1008);
        step(mk(4'b0000, 0, 4'b0000, 0, 0, 0), 1009);
        step(mk(4'b0000, 0, 4'b0000, 0, 0, 0), 1010);
        #2;
        reset = 1'b0;
        #1;
        checkIdle("async_idle");
        #1;
        reset = 1'b1;
        step(mk(4'b0110, 0, 4'b0010, 0, 0, 0), 1011);
        step(mk(4'b0000, 0, 4'b0000, 0, 0, 0), 1012);

        check("queue_empty", -1, 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
